// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, active-video enable, h/v sync and line/frame pulses.
// Optional completed-frame counter on o_frame_cnt when VGA_FRAME_CNT_EN is defined (tied to 0 otherwise).
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_de,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 65535) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL exceeds 65535");
    end
    if (V_TOTAL > 65535) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL exceeds 65535");
    end

    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] h_cnt_q, h_cnt_d;
    logic [15:0] v_cnt_q, v_cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        ls_q, ls_d;
    logic        fs_q, fs_d;

    // Raster counter next state
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (i_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 16'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 16'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 16'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 16'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Output decode from the pre-increment counter values; pulses drop on stalled cycles
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (i_en) begin
            x_d  = h_cnt_q;
            y_d  = v_cnt_q;
            de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            hs_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? H_POL : ~H_POL;
            vs_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? V_POL : ~V_POL;
            ls_d = (h_cnt_q == 16'd0);
            fs_d = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
        end else begin
            ls_d = 1'b0;
            fs_d = 1'b0;
        end
    end

    // Counter and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_q <= 16'd0;
            v_cnt_q <= 16'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            de_q    <= 1'b0;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt_q, fcnt_d;
    logic        seen_q, seen_d;

    // The first frame_start after reset opens frame 0 and is not a completed frame
    always_comb begin
        fcnt_d = fcnt_q;
        seen_d = seen_q;
        if (fs_d) begin
            seen_d = 1'b1;
            if (seen_q) begin
                fcnt_d = fcnt_q + 16'd1;
            end else begin
                fcnt_d = fcnt_q;
            end
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Frame counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fcnt_q <= 16'd0;
            seen_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            seen_q <= seen_d;
        end
    end

    assign o_frame_cnt = fcnt_q;
`else
    assign o_frame_cnt = 16'd0;
`endif

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_de          = de_q;
    assign o_h_sync      = hs_q;
    assign o_v_sync      = vs_q;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster; every enabled/stalled cycle is compared to a reference model.
module tb_vga_timing_gen;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic [15:0] o_x, o_y, o_frame_cnt;
    logic        o_de, o_h_sync, o_v_sync, o_line_start, o_frame_start;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          mx, my;
    logic [15:0] ex, ey, efc;
    logic        ede, ehs, evs, els, efs, seen;
    int          en_cnt, last_fs;
    bit          last_fs_valid;
    logic        prev_vs;
    int          vs_rises;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .o_x(o_x), .o_y(o_y), .o_de(o_de),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start),
        .o_frame_cnt(o_frame_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0;
        ex = 16'd0; ey = 16'd0; efc = 16'd0;
        ede = 1'b0; ehs = 1'b0; evs = 1'b0; els = 1'b0; efs = 1'b0; seen = 1'b0;
        last_fs_valid = 1'b0;
        prev_vs = 1'b0;
    endtask

    task automatic model_step(input logic en);
        if (en) begin
            ex  = 16'(mx);
            ey  = 16'(my);
            ede = (mx < 8) && (my < 4);
            ehs = (mx >= 10) && (mx < 13);
            evs = (my >= 5) && (my < 7);
            els = (mx == 0);
            efs = (mx == 0) && (my == 0);
`ifdef VGA_FRAME_CNT_EN
            if (efs) begin
                if (seen) efc = efc + 16'd1;
                seen = 1'b1;
            end
`endif
            mx = mx + 1;
            if (mx == 16) begin
                mx = 0;
                my = (my == 7) ? 0 : my + 1;
            end
        end else begin
            els = 1'b0;
            efs = 1'b0;
        end
    endtask

    // one clock with the given enable, then compare all outputs 1 time unit after the edge
    task automatic tick(input logic en, input string tag);
        i_en = en;
        @(posedge i_clk);
        #1;
        model_step(en);
        if (en) en_cnt++;
        check_val(tag, {11'd0, o_x, o_y, o_frame_cnt, o_de, o_h_sync, o_v_sync, o_line_start, o_frame_start},
                       {11'd0, ex, ey, efc, ede, ehs, evs, els, efs});
        if (o_v_sync && !prev_vs) vs_rises++;
        prev_vs = o_v_sync;
        if (o_frame_start) begin
            if (last_fs_valid) check_val("frame_period", 64'(en_cnt - last_fs), 64'd128);
            last_fs       = en_cnt;
            last_fs_valid = 1'b1;
        end
    endtask

    initial begin
        int guard;
        en_cnt   = 0;
        last_fs  = 0;
        vs_rises = 0;
        i_en     = 1'b1;
        i_rst_n  = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_val("reset_state", {o_x, o_y, o_frame_cnt, 11'd0, o_de, o_h_sync, o_v_sync, o_line_start, o_frame_start},
                                 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // two full frames, always enabled
        for (int i = 0; i < 256; i++) tick(1'b1, "raster_en");
        check_val("vs_rises_2frames", 64'(vs_rises), 64'd2);

        // enable pattern 1,0,0,1 for a little over two frames of enabled cycles
        for (int i = 0; i < 600; i++) tick((i % 4 == 0) || (i % 4 == 3), "raster_toggle");

        // walk to x=11,y=5 where both syncs are active, then reset mid-sync
        guard = 0;
        do begin
            tick(1'b1, "seek_sync");
            guard++;
        end while (!(ex == 16'd11 && ey == 16'd5) && guard < 200);
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL seek_sync_timeout: got x=%0d y=%0d expected x=11 y=5", o_x, o_y);
        end
        check_val("pre_reset_syncs", {62'd0, o_h_sync, o_v_sync}, 64'd3);
        i_rst_n = 1'b0;
        #1;
        check_val("async_reset", {o_x, o_y, o_frame_cnt, 11'd0, o_de, o_h_sync, o_v_sync, o_line_start, o_frame_start},
                                 64'd0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // restart from (0,0), run three frames for the frame counter
        for (int i = 0; i < 3 * 128 + 4; i++) tick(1'b1, "restart");
`ifdef VGA_FRAME_CNT_EN
        check_val("frame_cnt_3", {48'd0, o_frame_cnt}, 64'd3);
`else
        check_val("frame_cnt_tied", {48'd0, o_frame_cnt}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
